// File: rtl/b_calc_ctrl_if.sv
// Keypad-side bundle for the calculator control stage: keypad entry and buttons in,
// keypad rearm pulses and display/status flags out.
interface b_calc_ctrl_if;
    logic [7:0] b_calc_keycode;
    logic       b_calc_new_input;
    logic       b_calc_overflow_flag;
    logic [4:0] b_calc_op_key;
    logic       b_calc_clear_key;
    logic       b_calc_op_valid_key_pressed;
    logic       b_calc_clear;
    logic [7:0] b_calc_display;
    logic       b_calc_negative;
    logic       b_calc_error;
    logic       b_calc_busy;

    modport master (
        output b_calc_keycode, b_calc_new_input, b_calc_overflow_flag,
               b_calc_op_key, b_calc_clear_key,
        input  b_calc_op_valid_key_pressed, b_calc_clear, b_calc_display,
               b_calc_negative, b_calc_error, b_calc_busy
    );

    modport slave (
        input  b_calc_keycode, b_calc_new_input, b_calc_overflow_flag,
               b_calc_op_key, b_calc_clear_key,
        output b_calc_op_valid_key_pressed, b_calc_clear, b_calc_display,
               b_calc_negative, b_calc_error, b_calc_busy
    );
endinterface

// File: rtl/b_calc_ctrl.sv
// Calculator control: operand/operator sequencing, add/sub/mul evaluation and a
// bit-serial restoring divider, driving sign-magnitude display and status flags.
module b_calc_ctrl #(
    parameter int         DIV_ITER = 8,
    parameter logic [7:0] ERR_CODE = 8'hEE
) (
    input  logic         i_sys_clock,
    input  logic         i_sys_reset,
    b_calc_ctrl_if.slave calc
);
    localparam int CNT_W = $clog2(DIV_ITER + 1);

    typedef enum logic [2:0] {S_A, S_B, S_RESULT, S_CALC, S_ERR} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    state_t           state_reg;
    op_t              op_reg, chain_op_reg, new_op;
    logic             chain_reg, b_entered_reg, sign_a_reg;
    logic [7:0]       mag_a_reg, div_b_reg, quo_reg, rem_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       op_prev_reg, op_edge;
    logic             clear_prev_reg, clear_edge;
    logic             op_valid_reg, clear_reg, negative_reg, error_reg, busy_reg;
    logic [7:0]       display_reg;

    logic             op_hit, arith_edge, equals_edge;
    logic signed [9:0] a_signed, b_signed, sum;
    logic [9:0]       sum_abs;
    logic [15:0]      prod;
    logic             eval_err, eval_neg;
    logic [7:0]       eval_mag;
    logic [8:0]       rem_shift, rem_sub;
    logic             fits, div_neg;
    logic [7:0]       rem_next, quo_next;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_op_edge
            assign op_edge[gi] = calc.b_calc_op_key[gi] & ~op_prev_reg[gi];
        end
    endgenerate

    // Simultaneous rises of several buttons are treated as no press at all.
    assign clear_edge  = calc.b_calc_clear_key & ~clear_prev_reg;
    assign op_hit      = $onehot(op_edge);
    assign arith_edge  = op_hit & (|op_edge[3:0]);
    assign equals_edge = op_hit & op_edge[4];

    always_comb begin
        new_op = OP_ADD;
        if (op_edge[1])      new_op = OP_SUB;
        else if (op_edge[2]) new_op = OP_MUL;
        else if (op_edge[3]) new_op = OP_DIV;
    end

    // Operand B is whatever the keypad currently shows on the evaluating edge.
    always_comb begin
        a_signed = $signed({2'b00, mag_a_reg});
        if (sign_a_reg) a_signed = -a_signed;
        b_signed = $signed({2'b00, calc.b_calc_keycode});
        sum      = (op_reg == OP_SUB) ? (a_signed - b_signed) : (a_signed + b_signed);
        sum_abs  = sum[9] ? -sum : sum;
        prod     = {8'd0, mag_a_reg} * {8'd0, calc.b_calc_keycode};
        eval_err = 1'b0;
        eval_mag = 8'd0;
        eval_neg = 1'b0;
        case (op_reg)
            OP_ADD, OP_SUB: begin
                eval_err = sum_abs > 10'd255;
                eval_mag = sum_abs[7:0];
                eval_neg = sum[9];
            end
            OP_MUL: begin
                eval_err = prod > 16'd255;
                eval_mag = prod[7:0];
                eval_neg = sign_a_reg & (prod[7:0] != 8'd0);
            end
            default: eval_err = (calc.b_calc_keycode == 8'd0);
        endcase
    end

    always_comb begin
        rem_shift = {rem_reg, quo_reg[7]};
        fits      = rem_shift >= {1'b0, div_b_reg};
        rem_sub   = rem_shift - {1'b0, div_b_reg};
        rem_next  = fits ? rem_sub[7:0] : rem_shift[7:0];
        quo_next  = {quo_reg[6:0], fits};
        div_neg   = sign_a_reg & (quo_next != 8'd0);
    end

    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state_reg <= S_A;       op_reg <= OP_ADD;     chain_op_reg <= OP_ADD;
            chain_reg <= 1'b0;      b_entered_reg <= 1'b0;
            sign_a_reg <= 1'b0;     mag_a_reg <= 8'd0;    div_b_reg <= 8'd0;
            quo_reg <= 8'd0;        rem_reg <= 8'd0;      cnt_reg <= '0;
            op_prev_reg <= 5'd0;    clear_prev_reg <= 1'b0;
            op_valid_reg <= 1'b0;   clear_reg <= 1'b0;    display_reg <= 8'd0;
            negative_reg <= 1'b0;   error_reg <= 1'b0;    busy_reg <= 1'b0;
        end else begin
            op_prev_reg    <= calc.b_calc_op_key;
            clear_prev_reg <= calc.b_calc_clear_key;
            op_valid_reg   <= 1'b0;
            clear_reg      <= 1'b0;
            if (clear_edge) begin
                state_reg <= S_A;       op_reg <= OP_ADD;     chain_reg <= 1'b0;
                b_entered_reg <= 1'b0;  sign_a_reg <= 1'b0;   mag_a_reg <= 8'd0;
                clear_reg <= 1'b1;      display_reg <= 8'd0;  negative_reg <= 1'b0;
                error_reg <= 1'b0;      busy_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_A: begin
                        display_reg  <= calc.b_calc_keycode;
                        negative_reg <= 1'b0;
                        if (calc.b_calc_overflow_flag) begin
                            state_reg <= S_ERR; display_reg <= ERR_CODE; error_reg <= 1'b1;
                        end else if (arith_edge) begin
                            sign_a_reg <= 1'b0;      mag_a_reg <= calc.b_calc_keycode;
                            op_reg <= new_op;        b_entered_reg <= 1'b0;
                            op_valid_reg <= 1'b1;    state_reg <= S_B;
                        end
                    end
                    S_B: begin
                        // Until B entry starts, the display keeps showing operand A / chained result.
                        if (b_entered_reg || calc.b_calc_new_input) begin
                            display_reg <= calc.b_calc_keycode;
                        end
                        if (calc.b_calc_overflow_flag) begin
                            state_reg <= S_ERR; display_reg <= ERR_CODE;
                            negative_reg <= 1'b0; error_reg <= 1'b1;
                        end else if (equals_edge || (arith_edge && b_entered_reg)) begin
                            op_valid_reg <= 1'b1;
                            if (eval_err) begin
                                state_reg <= S_ERR; display_reg <= ERR_CODE;
                                negative_reg <= 1'b0; error_reg <= 1'b1;
                            end else if (op_reg == OP_DIV) begin
                                state_reg <= S_CALC;     busy_reg <= 1'b1;
                                div_b_reg <= calc.b_calc_keycode;
                                quo_reg <= mag_a_reg;    rem_reg <= 8'd0;   cnt_reg <= '0;
                                chain_reg <= arith_edge; chain_op_reg <= new_op;
                            end else begin
                                display_reg <= eval_mag; negative_reg <= eval_neg;
                                if (arith_edge) begin
                                    sign_a_reg <= eval_neg;  mag_a_reg <= eval_mag;
                                    op_reg <= new_op;        b_entered_reg <= 1'b0;
                                end else begin
                                    state_reg <= S_RESULT;
                                end
                            end
                        end else if (arith_edge) begin
                            op_reg <= new_op;
                            op_valid_reg <= 1'b1;
                        end else if (calc.b_calc_new_input) begin
                            b_entered_reg <= 1'b1;
                            negative_reg  <= 1'b0;
                        end
                    end
                    S_CALC: begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(DIV_ITER - 1)) begin
                            busy_reg <= 1'b0;  display_reg <= quo_next;  negative_reg <= div_neg;
                            if (chain_reg) begin
                                sign_a_reg <= div_neg;  mag_a_reg <= quo_next;
                                op_reg <= chain_op_reg; b_entered_reg <= 1'b0;
                                chain_reg <= 1'b0;      state_reg <= S_B;
                            end else begin
                                state_reg <= S_RESULT;
                            end
                        end
                    end
                    S_RESULT: begin
                        if (arith_edge) begin
                            sign_a_reg <= negative_reg; mag_a_reg <= display_reg;
                            op_reg <= new_op;           b_entered_reg <= 1'b0;
                            op_valid_reg <= 1'b1;       state_reg <= S_B;
                        end else if (calc.b_calc_new_input) begin
                            negative_reg <= 1'b0;
                            display_reg  <= calc.b_calc_keycode;
                            state_reg    <= S_A;
                        end
                    end
                    default: begin
                        display_reg <= ERR_CODE;
                        error_reg   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign calc.b_calc_op_valid_key_pressed = op_valid_reg;
    assign calc.b_calc_clear                = clear_reg;
    assign calc.b_calc_display              = display_reg;
    assign calc.b_calc_negative             = negative_reg;
    assign calc.b_calc_error                = error_reg;
    assign calc.b_calc_busy                 = busy_reg;
endmodule
